// File: rtl/painterengine_gpu_reader_fifo_pkg.sv
// -----------------------------------------------------------------------------
// painterengine_gpu_pkg
// Shared definitions for the GPU DMA reader channel blocks.
//   WORD_W  : width of one reader channel word
//   state_t : job FSM states of the reader elastic stage
// -----------------------------------------------------------------------------
package painterengine_gpu_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_RUN   = 3'b001,
        ST_DRAIN = 3'b010,
        ST_DONE  = 3'b011,
        ST_ERROR = 3'b111
    } state_t;

endpackage

// File: rtl/painterengine_gpu_reader_fifo_mem.sv
// -----------------------------------------------------------------------------
// painterengine_gpu_fifo_mem
// 2**ADDR_W x DATA_W storage for the reader FIFO. Synchronous write,
// asynchronous (distributed) read so the head word falls through.
//   i_clk    : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : read data (combinational)
// -----------------------------------------------------------------------------
module painterengine_gpu_fifo_mem
    import painterengine_gpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = WORD_W
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [1 << ADDR_W];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/painterengine_gpu_reader_fifo.sv
// -----------------------------------------------------------------------------
// painterengine_gpu_reader_fifo
// Downstream elastic stage for one GPU DMA reader channel: FWFT FIFO between
// the reader (valid/next) and the pixel pipeline (valid/ready), with a job
// word counter that reports done/error per job.
// Optional feature: define PAINTERENGINE_GPU_READER_FIFO_SWAP_EN to swap
// bytes 0 and 2 of the output word (ARGB<->ABGR).
// Ports:
//   i_wire_clock / i_wire_resetn : clock, async active-low reset
//   i_wire_start / i_wire_flush  : job start pulse (latches i_wire_length), sync clear
//   i_wire_length                : job length in words
//   i_wire_data/_valid, o_wire_data_next : reader-side handshake
//   o_wire_out_data/_valid, i_wire_out_ready : consumer-side handshake
//   o_wire_level, o_wire_almost_full : occupancy, level >= AF_THRESHOLD
//   o_wire_done, o_wire_error    : job finished / job error (sticky)
// -----------------------------------------------------------------------------
module painterengine_gpu_reader_fifo
    import painterengine_gpu_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2   = 5,
    parameter int unsigned AF_THRESHOLD = 28
) (
    input  logic                  i_wire_clock,
    input  logic                  i_wire_resetn,
    input  logic                  i_wire_start,
    input  logic                  i_wire_flush,
    input  logic [WORD_W-1:0]     i_wire_length,
    input  logic [WORD_W-1:0]     i_wire_data,
    input  logic                  i_wire_data_valid,
    output logic                  o_wire_data_next,
    output logic [WORD_W-1:0]     o_wire_out_data,
    output logic                  o_wire_out_valid,
    input  logic                  i_wire_out_ready,
    output logic [DEPTH_LOG2:0]   o_wire_level,
    output logic                  o_wire_almost_full,
    output logic                  o_wire_done,
    output logic                  o_wire_error
);

    localparam int unsigned          DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  C_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]  C_AF    = (DEPTH_LOG2 + 1)'(AF_THRESHOLD);

    state_t              r_state;
    state_t              w_state_nx;
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic [WORD_W-1:0]   r_length;
    logic [WORD_W-1:0]   r_in_count;
    logic [WORD_W-1:0]   r_out_count;

    logic [DEPTH_LOG2:0] w_level;
    logic                w_full;
    logic                w_empty;
    logic                w_next;
    logic                w_push;
    logic                w_pop;
    logic                w_job_start;
    logic [WORD_W-1:0]   w_rdata;

    // Extra pointer MSB makes the difference equal DEPTH when full after wrap.
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_level == C_DEPTH);
    assign w_empty = (w_level == '0);

    // start and flush outrank the handshake, so the reader is not offered a
    // slot in those cycles; a pop during flush is dropped with the FIFO.
    assign w_next = (r_state == ST_RUN) && !w_full && !i_wire_start && !i_wire_flush;
    assign w_push = w_next && i_wire_data_valid;
    assign w_pop  = !w_empty && i_wire_out_ready && !i_wire_flush;

    always_comb begin
        w_state_nx  = r_state;
        w_job_start = 1'b0;
        if (i_wire_flush) begin
            w_state_nx = ST_IDLE;
        end else if (i_wire_start) begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_wire_length == '0) begin
                        w_state_nx = ST_ERROR;
                    end else begin
                        w_state_nx  = ST_RUN;
                        w_job_start = 1'b1;
                    end
                end
                default: w_state_nx = ST_ERROR;
            endcase
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_push && (r_in_count + 32'd1 == r_length)) begin
                        w_state_nx = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((r_out_count == r_length) && w_empty) begin
                        w_state_nx = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_length    <= '0;
            r_in_count  <= '0;
            r_out_count <= '0;
        end else begin
            r_state <= w_state_nx;
            if (i_wire_flush) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_in_count  <= '0;
                r_out_count <= '0;
            end else begin
                if (w_job_start) begin
                    r_length    <= i_wire_length;
                    r_in_count  <= '0;
                    r_out_count <= '0;
                end else begin
                    if (w_push) r_in_count  <= r_in_count + 32'd1;
                    if (w_pop)  r_out_count <= r_out_count + 32'd1;
                end
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    painterengine_gpu_fifo_mem #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (WORD_W)
    ) u_mem (
        .i_clk   (i_wire_clock),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[DEPTH_LOG2-1:0]),
        .i_wdata (i_wire_data),
        .i_raddr (r_rd_ptr[DEPTH_LOG2-1:0]),
        .o_rdata (w_rdata)
    );

    // Output word is forced to zero while empty so nothing uninitialised leaks out.
`ifdef PAINTERENGINE_GPU_READER_FIFO_SWAP_EN
    assign o_wire_out_data = w_empty ? '0 : {w_rdata[31:24], w_rdata[7:0], w_rdata[15:8], w_rdata[23:16]};
`else
    assign o_wire_out_data = w_empty ? '0 : w_rdata;
`endif

    assign o_wire_data_next   = w_next;
    assign o_wire_out_valid   = !w_empty;
    assign o_wire_level       = w_level;
    assign o_wire_almost_full = (w_level >= C_AF);
    assign o_wire_done        = (r_state == ST_DONE);
    assign o_wire_error       = (r_state == ST_ERROR);

endmodule

// File: tb/tb_painterengine_gpu_reader_fifo.sv
module tb_painterengine_gpu_reader_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, flush, dv, rdy;
    logic [31:0] len, data, odata;
    logic        next, oval, af, done, err;
    logic [5:0]  level;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    painterengine_gpu_reader_fifo #(
        .DEPTH_LOG2   (5),
        .AF_THRESHOLD (28)
    ) dut (
        .i_wire_clock       (clk),
        .i_wire_resetn      (rst_n),
        .i_wire_start       (start),
        .i_wire_flush       (flush),
        .i_wire_length      (len),
        .i_wire_data        (data),
        .i_wire_data_valid  (dv),
        .o_wire_data_next   (next),
        .o_wire_out_data    (odata),
        .o_wire_out_valid   (oval),
        .i_wire_out_ready   (rdy),
        .o_wire_level       (level),
        .o_wire_almost_full (af),
        .o_wire_done        (done),
        .o_wire_error       (err)
    );

    localparam logic [31:0] W0 = 32'h11223344;
    localparam logic [31:0] W1 = 32'hA5A50001;
    localparam logic [31:0] W2 = 32'h0BADF00D;
    localparam logic [31:0] W3 = 32'h12345678;
`ifdef PAINTERENGINE_GPU_READER_FIFO_SWAP_EN
    localparam logic [31:0] EXP_W0 = 32'h11443322;
`else
    localparam logic [31:0] EXP_W0 = 32'h11223344;
`endif

    function automatic logic [31:0] expw(input logic [31:0] w);
`ifdef PAINTERENGINE_GPU_READER_FIFO_SWAP_EN
        return {w[31:24], w[7:0], w[15:8], w[23:16]};
`else
        return w;
`endif
    endfunction

    typedef struct {
        string       nm;
        logic        st, fl;
        logic [31:0] ln, d;
        logic        v, r;
        logic        e_next, e_oval;
        logic [31:0] e_data;
        logic [5:0]  e_lvl;
        logic        e_af, e_done, e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string nm, input logic st, fl, input logic [31:0] ln, d,
                                input logic v, r, input logic e_next, e_oval,
                                input logic [31:0] e_data, input logic [5:0] e_lvl,
                                input logic e_af, e_done, e_err);
        vec_t t;
        t.nm = nm; t.st = st; t.fl = fl; t.ln = ln; t.d = d; t.v = v; t.r = r;
        t.e_next = e_next; t.e_oval = e_oval; t.e_data = e_data; t.e_lvl = e_lvl;
        t.e_af = e_af; t.e_done = e_done; t.e_err = e_err;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, f, input logic [31:0] l, d, input logic v, r);
        start = s; flush = f; len = l; data = d; dv = v; rdy = r;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Streams n words with ready held low for the first 'hold' cycles, checking
    // level/flags against a push/pop count model and data order every cycle.
    task automatic stream(input int n, input int hold, input logic [31:0] base, output int maxlvl);
        int pushed, popped, exl;
        logic p, q;
        pushed = 0; popped = 0; maxlvl = 0;
        drive(1'b1, 1'b0, n, 32'h0, 1'b0, 1'b0);
        cyc();
        for (int c = 0; c < 300 && popped < n; c++) begin
            drive(1'b0, 1'b0, 32'h0, base + pushed, pushed < n, c >= hold);
            #2;
            exl = pushed - popped;
            if (exl > maxlvl) maxlvl = exl;
            chk("s_level", 64'(level), 64'(exl));
            chk("s_af",    64'(af),    64'(exl >= 28));
            chk("s_next",  64'(next),  64'((pushed < n) && (exl < 32)));
            chk("s_oval",  64'(oval),  64'(exl > 0));
            if (exl > 0) chk("s_data", 64'(odata), 64'(expw(base + popped)));
            p = dv && next;
            q = oval && rdy;
            cyc();
            if (p) pushed++;
            if (q) popped++;
        end
        chk("s_popped", 64'(popped), 64'(n));
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int c = 0; c < 4 && !done; c++) cyc();
        #2;
        chk("s_done", 64'(done), 64'd1);
        chk("s_done_next", 64'(next), 64'd0);
        cyc();
    endtask

    initial begin
        int mx;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #12;
        chk("rst_outs", {next, oval, level, af, done, err}, '0);
        chk("rst_data", 64'(odata), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // length-4 stream, FWFT latency, DONE; then zero-length start -> ERROR -> flush
        tbl.push_back(mk("idle",      0,0,32'd0,32'h0,      0,0, 0,0,32'h0,      6'd0,0,0,0));
        tbl.push_back(mk("start4",    1,0,32'd4,32'h0,      0,1, 0,0,32'h0,      6'd0,0,0,0));
        tbl.push_back(mk("push0",     0,0,32'd0,W0,         1,1, 1,0,32'h0,      6'd0,0,0,0));
        tbl.push_back(mk("push1",     0,0,32'd0,W1,         1,1, 1,1,EXP_W0,     6'd1,0,0,0));
        tbl.push_back(mk("push2",     0,0,32'd0,W2,         1,1, 1,1,expw(W1),   6'd1,0,0,0));
        tbl.push_back(mk("push3",     0,0,32'd0,W3,         1,1, 1,1,expw(W2),   6'd1,0,0,0));
        tbl.push_back(mk("drain",     0,0,32'd0,32'hDEADBEEF,1,1,0,1,expw(W3),   6'd1,0,0,0));
        tbl.push_back(mk("drained",   0,0,32'd0,32'h0,      0,1, 0,0,32'h0,      6'd0,0,0,0));
        tbl.push_back(mk("done",      0,0,32'd0,32'h0,      0,1, 0,0,32'h0,      6'd0,0,1,0));
        tbl.push_back(mk("done_hold", 0,0,32'd0,32'h77,     1,1, 0,0,32'h0,      6'd0,0,1,0));
        tbl.push_back(mk("start0",    1,0,32'd0,32'h0,      0,1, 0,0,32'h0,      6'd0,0,1,0));
        tbl.push_back(mk("error",     0,0,32'd0,32'h55,     1,1, 0,0,32'h0,      6'd0,0,0,1));
        tbl.push_back(mk("flush",     0,1,32'd0,32'h0,      0,0, 0,0,32'h0,      6'd0,0,0,1));
        tbl.push_back(mk("idle2",     0,0,32'd0,32'h0,      0,0, 0,0,32'h0,      6'd0,0,0,0));

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].fl, tbl[i].ln, tbl[i].d, tbl[i].v, tbl[i].r);
            #2;
            chk(tbl[i].nm, {next, oval, level, af, done, err},
                {tbl[i].e_next, tbl[i].e_oval, tbl[i].e_lvl, tbl[i].e_af, tbl[i].e_done, tbl[i].e_err});
            if (tbl[i].e_oval) chk({tbl[i].nm, "_data"}, 64'(odata), 64'(tbl[i].e_data));
            cyc();
        end

        // length 40 with the consumer stalled: fills to 32, then drains in order
        stream(40, 45, 32'hC0DE0000, mx);
        chk("fill_max", 64'(mx), 64'd32);

        // flush at level 10 with push+pop in the same cycle
        drive(1'b1, 1'b0, 32'd20, 32'h0, 1'b0, 1'b0);
        cyc();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h100 + i, 1'b1, 1'b0);
            cyc();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("pre_flush_lvl", 64'(level), 64'd10);
        cyc();
        drive(1'b0, 1'b1, 32'h0, 32'h999, 1'b1, 1'b1);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("post_flush", {next, oval, level, af, done, err}, '0);
        cyc();
        drive(1'b1, 1'b0, 32'd1, 32'h0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 32'hCAFE0001, 1'b1, 1'b0);
        #2;
        chk("reuse_next", 64'(next), 64'd1);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        #2;
        chk("reuse_lvl", 64'(level), 64'd1);
        chk("reuse_data", 64'(odata), 64'(expw(32'hCAFE0001)));
        cyc();
        cyc();
        #2;
        chk("reuse_done", 64'(done), 64'd1);
        cyc();

        // start while RUN with 3 of 8 words in: ERROR, buffered words still drain
        drive(1'b1, 1'b0, 32'd8, 32'h0, 1'b0, 1'b0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h500 + i, 1'b1, 1'b0);
            cyc();
        end
        drive(1'b1, 1'b0, 32'd8, 32'h5FF, 1'b1, 1'b0);
        #2;
        chk("restart_err_pre", 64'(err), 64'd0);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("restart_err", {next, level, err}, {1'b0, 6'd3, 1'b1});
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            #2;
            chk("err_pop_valid", 64'(oval), 64'd1);
            chk("err_pop_data", 64'(odata), 64'(expw(32'h500 + i)));
            cyc();
        end
        #2;
        chk("err_drained", {oval, level, err}, {1'b0, 6'd0, 1'b1});
        drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("err_cleared", 64'(err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
